timing_sequencer: RTL and testbench

TIMING_SEQUENCER -- requirements
Module: timing_sequencer

---
 rtl/timing_sequencer.sv | 91 +++++++++
 tb/tb_timing_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/timing_sequencer.sv
// Instruction timing-state sequencer: steps a T-state counter on falling clock
// edges under command control, tracks a level interrupt and a sticky error.
module timing_sequencer #(
    parameter int W     = 3,
    parameter int MAX_T = 6
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_rdy,
    input  logic [1:0]   i_cmd,
    input  logic [W-1:0] i_load,
    input  logic         i_irq,
    output logic [W-1:0] o_tcu,
    output logic         o_sync,
    output logic         o_t0,
    output logic         o_irq_pending,
    output logic         o_irq_take,
    output logic         o_err
);

    localparam logic [1:0]   CMD_INC     = 2'b00;
    localparam logic [1:0]   CMD_RESTART = 2'b01;
    localparam logic [1:0]   CMD_LOAD    = 2'b10;
    localparam logic [1:0]   CMD_SKIP    = 2'b11;
    localparam logic [W-1:0] MAX_V       = W'(MAX_T);
    localparam logic [W-1:0] ALL_ONES    = '1;

    logic [W-1:0] tcu_q, tcu_d;
    logic         irq_pending_q, irq_pending_d;
    logic         irq_take_q, irq_take_d;
    logic         err_q, err_d;

    always_comb begin
        tcu_d         = tcu_q;
        irq_pending_d = irq_pending_q;
        irq_take_d    = irq_take_q;
        err_d         = err_q;
        if (i_rdy) begin
            if (i_irq) irq_pending_d = 1'b1;
            case (i_cmd)
                CMD_INC: begin
                    // All-ones is the post-reset state, so it wraps silently.
                    if (tcu_q == MAX_V) begin
                        tcu_d = '0;
                        err_d = 1'b1;
                    end else begin
                        tcu_d = tcu_q + W'(1);
                    end
                end
                CMD_RESTART: begin
                    // Instruction boundary: an irq arriving now is taken, not queued.
                    tcu_d         = '0;
                    irq_take_d    = irq_pending_q | i_irq;
                    irq_pending_d = 1'b0;
                end
                CMD_LOAD: begin
                    if ((i_load > MAX_V) && (i_load != ALL_ONES)) begin
                        tcu_d = '0;
                        err_d = 1'b1;
                    end else begin
                        tcu_d = i_load;
                    end
                end
                CMD_SKIP: tcu_d = W'(2);
                default:  tcu_d = tcu_q;
            endcase
        end
    end

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tcu_q         <= ALL_ONES;
            irq_pending_q <= 1'b0;
            irq_take_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            tcu_q         <= tcu_d;
            irq_pending_q <= irq_pending_d;
            irq_take_q    <= irq_take_d;
            err_q         <= err_d;
        end
    end

    assign o_tcu         = tcu_q;
    assign o_sync        = (tcu_q == W'(1));
    assign o_t0          = (tcu_q == '0);
    assign o_irq_pending = irq_pending_q;
    assign o_irq_take    = irq_take_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed vector bench for timing_sequencer (W=3, MAX_T=6).
module tb_timing_sequencer;

    logic       clk = 1'b1;
    logic       rst_n;
    logic       rdy;
    logic [1:0] cmd;
    logic [2:0] load;
    logic       irq;
    logic [2:0] tcu;
    logic       sync, t0, pend, take, err;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] INC = 2'b00, RST = 2'b01, LD = 2'b10, SKP = 2'b11;

    timing_sequencer #(.W(3), .MAX_T(6)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_rdy(rdy), .i_cmd(cmd),
        .i_load(load), .i_irq(irq), .o_tcu(tcu), .o_sync(sync), .o_t0(t0),
        .o_irq_pending(pend), .o_irq_take(take), .o_err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       arst;
        logic       rdy;
        logic [1:0] cmd;
        logic [2:0] load;
        logic       irq;
        logic [2:0] tcu;
        logic       pend;
        logic       take;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic a, logic r, logic [1:0] c, logic [2:0] l, logic i,
                               logic [2:0] et, logic ep, logic ek, logic ee);
        vec_t x;
        x.arst = a; x.rdy = r; x.cmd = c; x.load = l; x.irq = i;
        x.tcu = et; x.pend = ep; x.take = ek; x.err = ee;
        return x;
    endfunction

    task automatic check(string name, int idx, logic [2:0] act, logic [2:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(int idx, vec_t e);
        check("tcu",  idx, tcu, e.tcu);
        check("sync", idx, {2'b0, sync}, {2'b0, e.tcu == 3'd1});
        check("t0",   idx, {2'b0, t0},   {2'b0, e.tcu == 3'd0});
        check("pend", idx, {2'b0, pend}, {2'b0, e.pend});
        check("take", idx, {2'b0, take}, {2'b0, e.take});
        check("err",  idx, {2'b0, err},  {2'b0, e.err});
    endtask

    initial begin
        // counting from reset, overflow past MAX_T
        for (int k = 0; k < 7; k++) vecs.push_back(v(0,1,INC,0,0, 3'(k),0,0,0));
        vecs.push_back(v(0,1,INC,0,0, 0,0,0,1));
        vecs.push_back(v(0,1,RST,0,0, 0,0,0,1));
        vecs.push_back(v(0,1,LD, 3,0, 3,0,0,1));
        vecs.push_back(v(0,1,INC,0,0, 4,0,0,1));
        // async reset, then stall with RESTART+irq ignored
        vecs.push_back(v(1,0,INC,0,0, 7,0,0,0));
        vecs.push_back(v(0,1,INC,0,0, 0,0,0,0));
        vecs.push_back(v(0,1,INC,0,0, 1,0,0,0));
        vecs.push_back(v(0,1,INC,0,0, 2,0,0,0));
        for (int k = 0; k < 3; k++) vecs.push_back(v(0,0,RST,0,1, 2,0,0,0));
        vecs.push_back(v(0,1,RST,0,1, 0,0,1,0));
        // irq pulse at tcu=3, held pending until RESTART
        vecs.push_back(v(0,1,INC,0,0, 1,0,1,0));
        vecs.push_back(v(0,1,INC,0,0, 2,0,1,0));
        vecs.push_back(v(0,1,RST,0,0, 0,0,0,0));
        vecs.push_back(v(0,1,INC,0,0, 1,0,0,0));
        vecs.push_back(v(0,1,INC,0,0, 2,0,0,0));
        vecs.push_back(v(0,1,INC,0,0, 3,0,0,0));
        vecs.push_back(v(0,1,INC,0,1, 4,1,0,0));
        vecs.push_back(v(0,0,RST,0,0, 4,1,0,0));
        vecs.push_back(v(0,1,INC,0,0, 5,1,0,0));
        vecs.push_back(v(0,1,INC,0,0, 6,1,0,0));
        vecs.push_back(v(0,1,RST,0,0, 0,0,1,0));
        vecs.push_back(v(0,1,SKP,0,0, 2,0,1,0));
        vecs.push_back(v(0,1,RST,0,0, 0,0,0,0));
        // LOAD / SKIP, all-ones load and wrap are legal
        vecs.push_back(v(0,1,LD, 5,0, 5,0,0,0));
        vecs.push_back(v(0,1,LD, 7,0, 7,0,0,0));
        vecs.push_back(v(0,1,INC,0,0, 0,0,0,0));
        vecs.push_back(v(0,1,LD, 6,0, 6,0,0,0));
        vecs.push_back(v(0,1,SKP,0,0, 2,0,0,0));
        // set up tcu=4, pending, take, err ahead of the mid-cycle reset
        vecs.push_back(v(0,1,RST,0,1, 0,0,1,0));
        vecs.push_back(v(0,1,LD, 6,1, 6,1,1,0));
        vecs.push_back(v(0,1,INC,0,0, 0,1,1,1));
        vecs.push_back(v(0,1,LD, 4,0, 4,1,1,1));

        rst_n = 1'b0; rdy = 1'b1; cmd = INC; load = '0; irq = 1'b0;
        @(negedge clk); #1;
        check_all(-1, v(1,0,INC,0,0, 7,0,0,0));
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].arst) begin
                #2 rst_n = 1'b0;
                #1 check_all(i, vecs[i]);
                rst_n = 1'b1;
            end else begin
                rdy = vecs[i].rdy; cmd = vecs[i].cmd; load = vecs[i].load; irq = vecs[i].irq;
                @(negedge clk); #1;
                check_all(i, vecs[i]);
            end
        end

        // reset between edges takes effect at once and holds across an edge
        rdy = 1'b1; cmd = INC; irq = 1'b1;
        #3 rst_n = 1'b0;
        #1 check_all(100, v(1,0,INC,0,0, 7,0,0,0));
        @(negedge clk); #1;
        check_all(101, v(1,0,INC,0,0, 7,0,0,0));
        irq = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk); #1;
        check_all(102, v(0,1,INC,0,0, 0,0,0,0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
